decrypt_engine: RTL



---
 rtl/aes_pkg.sv | 86 ++++++++
 rtl/aes_inv_round.sv | 50 +++++
 rtl/decrypt_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, FSM encoding, S-box tables and GF(2^8) helpers
// used by the decryption engine and its inverse-round datapath.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0]      aes_state_t;
  // Byte view of a block: element 0 is bits [127:120], i.e. FIPS-197 byte 0.
  typedef logic [0:15][7:0]  aes_bytes_t;

  typedef enum logic [2:0] {
    IDLE,
    KEY_GEN,
    READY,
    BUSY,
    DONE
  } fsm_e;

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless 'last' is set (final round).
module aes_inv_round
  import aes_pkg::*;
(
  input  aes_state_t state_in,
  input  aes_state_t round_key,
  input  logic       last,
  output aes_state_t state_out
);

  aes_bytes_t in_b;
  aes_bytes_t key_b;
  aes_bytes_t keyed_b;
  aes_bytes_t mixed_b;

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  assign in_b  = state_in;
  assign key_b = round_key;

  // Row r of column c comes from column (c - r) mod 4: a right rotate by r.
  always_comb begin
    // NOTE: default-assign every combinational output first so no path can infer a latch.
    keyed_b = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        keyed_b[4*c + r] = INV_SBOX[in_b[4*((c + 4 - r) % 4) + r]] ^ key_b[4*c + r];
      end
    end
  end

  always_comb begin
    mixed_b = '0;
    for (int c = 0; c < 4; c++) begin
      {mixed_b[4*c], mixed_b[4*c + 1], mixed_b[4*c + 2], mixed_b[4*c + 3]} =
        inv_mix_column({keyed_b[4*c], keyed_b[4*c + 1], keyed_b[4*c + 2], keyed_b[4*c + 3]});
    end
  end

  assign state_out = last ? keyed_b : mixed_b;

endmodule

// File: rtl/decrypt_engine.sv
// Iterative AES-128 decryption engine: expands the key once into 11 round keys,
// then decrypts one block per 12 cycles. Optional macro DECRYPT_ZEROIZE_EN.
module decrypt_engine
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         set_key,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         halt,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
`ifdef DECRYPT_ZEROIZE_EN
  ,
  output logic         zeroized
`endif
);

  fsm_e       state;
  fsm_e       state_nxt;
  logic [3:0] idx;
  logic [3:0] rnd;
  aes_state_t st;
  aes_state_t rk [0:NR];
  aes_state_t rk_next;
  aes_state_t round_out;
  logic       key_load;
  logic       accept;
  logic       last_round;

  function automatic aes_state_t expand_step(input aes_state_t prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = prev;
    t  = sub_word(rot_word(w3)) ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign rk_next = expand_step(rk[idx - 4'd1], RCON[idx]);

  aes_inv_round u_inv_round (
    .state_in  (st),
    .round_key (rk[rnd]),
    .last      (last_round),
    .state_out (round_out)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // halt overrides every transition; set_key outranks a same-cycle block in READY.
  always_comb begin
    state_nxt = state;
    if (halt) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (set_key) state_nxt = KEY_GEN;
        KEY_GEN: if (idx == 4'(NR)) state_nxt = READY;
        READY:   if (set_key) state_nxt = KEY_GEN;
                 else if (in_valid) state_nxt = BUSY;
        BUSY:    if (last_round) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = READY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    key_ready  = (state == READY) || (state == BUSY) || (state == DONE);
    in_ready   = (state == READY) && !set_key && !halt;
    key_load   = set_key && !halt && ((state == IDLE) || (state == READY));
    accept     = in_valid && in_ready;
    last_round = (rnd == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      rnd       <= '0;
      st        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      // NOTE: the round-key store is reset explicitly, so it must stay in flops rather than a RAM macro.
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (halt) begin
      out_valid <= 1'b0;
`ifdef DECRYPT_ZEROIZE_EN
      st       <= '0;
      out_data <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
`endif
    end else begin
      if (key_load) begin
        rk[0] <= key;
        idx   <= 4'd1;
      end
      if (state == KEY_GEN) begin
        rk[idx] <= rk_next;
        idx     <= idx + 4'd1;
      end
      if (accept) begin
        st  <= in_data ^ rk[NR];
        rnd <= 4'(NR - 1);
      end
      if (state == BUSY) begin
        st  <= round_out;
        rnd <= rnd - 4'd1;
        if (last_round) begin
          out_data  <= round_out;
          out_valid <= 1'b1;
        end
      end
      if ((state == DONE) && out_ready) out_valid <= 1'b0;
    end
  end

`ifdef DECRYPT_ZEROIZE_EN
  // One-cycle pulse marking the cycle after key material was wiped.
  always_ff @(posedge clk) begin
    if (rst) zeroized <= 1'b0;
    else     zeroized <= halt;
  end
`endif

endmodule
